// File: rtl/uart_rx_cfg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg_if
// Description : Holding-register handshake and status flags of the UART receiver.
// Revision    : 1.0
// ============================================================================
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_Rx_Ready;
   logic                 o_Rx_Valid;
   logic [DATA_BITS-1:0] o_Rx_Byte;
   logic                 o_Parity_Err;
   logic                 o_Frame_Err;
   logic                 o_Break;
   logic                 o_Overrun;

   // master is the word consumer, slave is the receiver
   modport master (
      output i_Rx_Ready,
      input  o_Rx_Valid, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
   );
   modport slave (
      input  i_Rx_Ready,
      output o_Rx_Valid, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Configurable UART receiver with parity/frame/break/overrun flags.
// Revision    : 1.0
// ============================================================================
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  wire logic    i_Clock,
   input  wire logic    i_Reset,
   input  wire logic    i_Rx_Serial,
   uart_rx_cfg_if.slave rx_bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int IDX_W = 4;

   localparam logic [CNT_W-1:0] c_HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] c_FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] c_LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] c_LAST_STOP = IDX_W'(STOP_BITS - 1);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_START   = 3'd1;
   localparam logic [2:0] c_DATA    = 3'd2;
   localparam logic [2:0] c_PARITY  = 3'd3;
   localparam logic [2:0] c_STOP    = 3'd4;
   localparam logic [2:0] c_CLEANUP = 3'd5;

   logic                 r_sync1, r_sync2;
   logic [2:0]           r_state, w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit, r_stop_err, r_stop0;
   logic                 r_valid, r_perr, r_ferr, r_brk, r_ovr;
   logic [DATA_BITS-1:0] r_byte;

   logic w_line, w_half_done, w_bit_done, w_load;
   logic w_first_stop, w_frame_err, w_par_err, w_break;

   assign w_line = r_sync2;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_Rx_Serial;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) r_state <= c_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:    if (!w_line) w_next_state = c_START;
         c_START:   if (w_half_done) w_next_state = w_line ? c_IDLE : c_DATA;
         c_DATA:    if (w_bit_done && r_idx == c_LAST_DATA)
                       w_next_state = (PARITY != 0) ? c_PARITY : c_STOP;
         c_PARITY:  if (w_bit_done) w_next_state = c_STOP;
         c_STOP:    if (w_bit_done && r_idx == c_LAST_STOP) w_next_state = c_CLEANUP;
         c_CLEANUP: if (w_line) w_next_state = c_IDLE;
         default:   w_next_state = c_IDLE;
      endcase
   end

   // The last stop sample is still on the line, so flags fold it in directly.
   always_comb begin
      w_half_done  = (r_cnt == c_HALF_CNT);
      w_bit_done   = (r_cnt == c_FULL_CNT);
      w_load       = (r_state == c_STOP) && w_bit_done && (r_idx == c_LAST_STOP);
      w_first_stop = (r_idx == '0) ? w_line : r_stop0;
      w_frame_err  = r_stop_err | ~w_line;
      w_par_err    = (PARITY != 0) && ((^r_shift ^ r_par_bit) != (PARITY == 1));
      w_break      = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_first_stop;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_stop_err <= 1'b0;
         r_stop0    <= 1'b0;
      end else begin
         case (r_state)
            c_START: r_cnt <= w_half_done ? '0 : r_cnt + CNT_W'(1);
            c_DATA: begin
               if (w_bit_done) begin
                  r_cnt   <= '0;
                  r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
                  r_idx   <= (r_idx == c_LAST_DATA) ? '0 : r_idx + IDX_W'(1);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            c_PARITY: begin
               if (w_bit_done) begin
                  r_cnt     <= '0;
                  r_par_bit <= w_line;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            c_STOP: begin
               if (w_bit_done) begin
                  r_cnt      <= '0;
                  r_idx      <= r_idx + IDX_W'(1);
                  r_stop_err <= r_stop_err | ~w_line;
                  if (r_idx == '0) r_stop0 <= w_line;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt      <= '0;
               r_idx      <= '0;
               r_stop_err <= 1'b0;
            end
         endcase
      end
   end

   // A load always wins over acceptance; overrun only when the old word was unread.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_valid <= 1'b0;
         r_byte  <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_brk   <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_byte  <= r_shift;
         r_perr  <= w_par_err;
         r_ferr  <= w_frame_err;
         r_brk   <= w_break;
         r_ovr   <= r_valid & ~rx_bus.i_Rx_Ready;
      end else if (r_valid && rx_bus.i_Rx_Ready) begin
         r_valid <= 1'b0;
      end
   end

   assign rx_bus.o_Rx_Valid   = r_valid;
   assign rx_bus.o_Rx_Byte    = r_byte;
   assign rx_bus.o_Parity_Err = r_perr;
   assign rx_bus.o_Frame_Err  = r_ferr;
   assign rx_bus.o_Break      = r_brk;
   assign rx_bus.o_Overrun    = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Scoreboard bench for uart_rx_cfg (8N1 and 8E2 instances).
// Revision    : 1.0
// ============================================================================
module tb_uart_rx_cfg;
   localparam int CPB = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
      logic       ovr;
   } word_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic line0 = 1'b1;
   logic line1 = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   word_t q0[$];
   word_t q1[$];
   word_t w_exp0, w_exp1, w_act0, w_act1;

   always #5 clk = ~clk;

   uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
   uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line0), .rx_bus(bus0.slave));
   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line1), .rx_bus(bus1.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: frame fields -> the word and flags the receiver should report.
   function automatic word_t model(input int dut, input logic [7:0] d, input logic p,
                                   input logic s0, input logic s1, input logic ovr);
      word_t w;
      w.data = d;
      w.ovr  = ovr;
      if (dut == 0) begin
         w.perr = 1'b0;
         w.ferr = (s0 == 1'b0);
         w.brk  = (d == 8'h00) && (s0 == 1'b0);
      end else begin
         w.perr = (($countones(d) + int'(p)) % 2) != 0;
         w.ferr = (s0 == 1'b0) || (s1 == 1'b0);
         w.brk  = (d == 8'h00) && (p == 1'b0) && (s0 == 1'b0);
      end
      return w;
   endfunction

   task automatic drive(input int dut, input logic v, input int cycles);
      if (dut == 0) line0 = v;
      else          line1 = v;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic send(input int dut, input logic [7:0] d, input logic p,
                       input logic s0, input logic s1, input bit push);
      if (push) begin
         if (dut == 0) q0.push_back(model(0, d, p, s0, s1, 1'b0));
         else          q1.push_back(model(1, d, p, s0, s1, 1'b0));
      end
      drive(dut, 1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(dut, d[i], CPB);
      if (dut == 1) drive(dut, p, CPB);
      drive(dut, s0, CPB);
      if (dut == 1) drive(dut, s1, CPB);
      drive(dut, 1'b1, 2);
   endtask

   task automatic chk_zero(input string name, input logic v, input logic [7:0] b,
                           input logic pe, input logic fe, input logic bk, input logic ov);
      chk({name, " valid"}, {31'd0, v}, 32'd0);
      chk({name, " byte"},  {24'd0, b}, 32'd0);
      chk({name, " perr"},  {31'd0, pe}, 32'd0);
      chk({name, " ferr"},  {31'd0, fe}, 32'd0);
      chk({name, " break"}, {31'd0, bk}, 32'd0);
      chk({name, " ovr"},   {31'd0, ov}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && bus0.o_Rx_Valid && bus0.i_Rx_Ready) begin
         w_act0 = {bus0.o_Rx_Byte, bus0.o_Parity_Err, bus0.o_Frame_Err, bus0.o_Break, bus0.o_Overrun};
         if (q0.size() == 0) begin
            n_checks++;
            $display("FAIL dut0 unexpected word: got %0h expected none", w_act0);
         end else begin
            w_exp0 = q0.pop_front();
            chk("dut0 word{byte,perr,ferr,brk,ovr}", {20'd0, w_act0}, {20'd0, w_exp0});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus1.o_Rx_Valid && bus1.i_Rx_Ready) begin
         w_act1 = {bus1.o_Rx_Byte, bus1.o_Parity_Err, bus1.o_Frame_Err, bus1.o_Break, bus1.o_Overrun};
         if (q1.size() == 0) begin
            n_checks++;
            $display("FAIL dut1 unexpected word: got %0h expected none", w_act1);
         end else begin
            w_exp1 = q1.pop_front();
            chk("dut1 word{byte,perr,ferr,brk,ovr}", {20'd0, w_act1}, {20'd0, w_exp1});
         end
      end
   end

   initial begin
      bus0.i_Rx_Ready = 1'b1;
      bus1.i_Rx_Ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset dut0", bus0.o_Rx_Valid, bus0.o_Rx_Byte, bus0.o_Parity_Err,
               bus0.o_Frame_Err, bus0.o_Break, bus0.o_Overrun);
      chk_zero("reset dut1", bus1.o_Rx_Valid, bus1.o_Rx_Byte, bus1.o_Parity_Err,
               bus1.o_Frame_Err, bus1.o_Break, bus1.o_Overrun);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Clean frame, then even parity right and wrong.
      send(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(0, 1'b1, CPB);
      send(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(1, 1'b1, CPB);
      send(1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1, 1'b1, CPB);

      // Framing error, then a long break that must yield a single word.
      send(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(0, 1'b1, CPB);
      q0.push_back(model(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(0, 1'b0, 20 * CPB);
      drive(0, 1'b1, 3 * CPB);
      send(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(0, 1'b1, CPB);

      // Short glitch is rejected; receiver still ready for a real start.
      drive(0, 1'b0, 4);
      drive(0, 1'b1, 2 * CPB);
      @(negedge clk);
      chk("glitch valid", {31'd0, bus0.o_Rx_Valid}, 32'd0);
      @(posedge clk); #1;
      send(0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(0, 1'b1, CPB);

      // Overrun: two words with nobody reading.
      bus0.i_Rx_Ready = 1'b0;
      send(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(0, 1'b1, 4);
      @(negedge clk);
      chk("held valid", {31'd0, bus0.o_Rx_Valid}, 32'd1);
      chk("held byte", {24'd0, bus0.o_Rx_Byte}, 32'h11);
      chk("held ovr", {31'd0, bus0.o_Overrun}, 32'd0);
      @(posedge clk); #1;
      q0.push_back(model(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1));
      send(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(0, 1'b1, 4);
      @(negedge clk);
      chk("overrun valid", {31'd0, bus0.o_Rx_Valid}, 32'd1);
      chk("overrun flag", {31'd0, bus0.o_Overrun}, 32'd1);
      @(posedge clk); #1;
      bus0.i_Rx_Ready = 1'b1;
      @(posedge clk); #1;
      bus0.i_Rx_Ready = 1'b0;
      @(negedge clk);
      chk("valid after accept", {31'd0, bus0.o_Rx_Valid}, 32'd0);
      @(posedge clk); #1;
      bus0.i_Rx_Ready = 1'b1;

      // Reset in the middle of data bit 3 of 0x3C.
      drive(0, 1'b0, CPB);
      drive(0, 1'b0, CPB);
      drive(0, 1'b0, CPB);
      drive(0, 1'b1, CPB);
      drive(0, 1'b1, CPB / 2);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("midframe reset", bus0.o_Rx_Valid, bus0.o_Rx_Byte, bus0.o_Parity_Err,
               bus0.o_Frame_Err, bus0.o_Break, bus0.o_Overrun);
      line0 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 1'b1, 2 * CPB);
      send(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(0, 1'b1, CPB);

      // Random frames on both receivers in parallel.
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               logic [7:0] d;
               logic       s0;
               d  = 8'($urandom);
               if ($urandom_range(0, 7) == 0) d = 8'h00;
               s0 = ($urandom_range(0, 7) != 0);
               send(0, d, 1'b0, s0, 1'b1, 1'b1);
               drive(0, 1'b1, $urandom_range(1, 2 * CPB));
            end
         end
         begin
            for (int j = 0; j < 12; j++) begin
               logic [7:0] d;
               logic       p, s0, s1;
               d  = 8'($urandom);
               if ($urandom_range(0, 7) == 0) d = 8'h00;
               p  = ($countones(d) % 2) != 0;
               if ($urandom_range(0, 3) == 0) p = ~p;
               s0 = ($urandom_range(0, 7) != 0);
               s1 = ($urandom_range(0, 7) != 0);
               send(1, d, p, s0, s1, 1'b1);
               drive(1, 1'b1, $urandom_range(1, 2 * CPB));
            end
         end
      join

      for (int k = 0; k < 4000 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
      chk("dut0 words outstanding", q0.size(), 32'd0);
      chk("dut1 words outstanding", q1.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
